lb_uart_rx_fsm: RTL and testbench
=================================

Name: lb_uart_rx_fsm

Overview:
UART receive sequencer that sits directly downstream of lb_16_n_8BaudTickCounter. It drives that counter's cs/load/_16_or_8_ticks inputs and consumes its one-cycle done pulse (btick) to locate the start-bit midpoint and each bit centre. It deserialises LSB-first frames into a byte register that the PicoBlaze reads through a valid/ack handshake, and it flags frame and overrun errors.

Parameters:
DATA_BITS, 8, number of data bits per frame (5..8)
SYNC_STAGES, 2, flops in the rx input synchroniser (>=2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rx  input  1  asynchronous serial line, idle high
btick  input  1  one-cycle pulse from the tick counter's done output
tick_cs  output  1  enable to the tick counter; high whenever the FSM is not IDLE
tick_load  output  1  one-cycle reload/restart strobe to the tick counter
tick_16_or_8  output  1  to _16_or_8_ticks; 0 = half-bit (8 ticks), 1 = full bit (16 ticks)
rd_ack  input  1  host read strobe; clears data_valid
data  output  DATA_BITS  last received byte
data_valid  output  1  byte available, held until rd_ack
frame_err  output  1  sticky; stop bit sampled low
overrun  output  1  sticky; byte completed while data_valid was still 1
err_clr  input  1  clears frame_err and overrun

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; data=0; data_valid=0; frame_err=0; overrun=0.
  - tick_cs=0; tick_load=0; tick_16_or_8=0.
  - bit_cnt=0; synchroniser flops preset to 1.
- Reset mid-frame aborts the frame. No partial byte is written.
- rx passes through SYNC_STAGES flops to give rx_s. Edge detect uses rx_s and its previous value rx_d.
- The tick counter restarts from zero on tick_load and auto-reloads while tick_cs=1. btick recurs every 8 or 16 counter periods.
- States: IDLE, START, DATA, STOP.
  - IDLE: when rx_d=1 and rx_s=0 (falling edge): go to START; pulse tick_load for 1 cycle with tick_16_or_8=0; tick_cs=1.
  - START: on btick (half-bit point):
    - rx_s=0: go to DATA; pulse tick_load with tick_16_or_8=1; clear bit_cnt.
    - rx_s=1: false start; go to IDLE; tick_cs=0; no flags change.
  - DATA: on each btick, shift = {rx_s, shift[DATA_BITS-1:1]} (LSB first) and bit_cnt increments. When bit_cnt reaches DATA_BITS-1 and btick occurs, go to STOP.
  - STOP: on btick:
    - rx_s=1: data<=shift; data_valid<=1; if data_valid was already 1 and no rd_ack that cycle, overrun<=1. Data is overwritten with the newest byte.
    - rx_s=0: frame_err<=1; data and data_valid are unchanged.
    - Either way, go to IDLE with tick_cs=0.
- Latency: data_valid rises on the clock edge after the btick that samples the stop bit.
- rd_ack and a new byte in the same cycle: the new byte wins (data_valid=1) and overrun is not set.
- rd_ack while data_valid=0 is ignored.
- err_clr and an error in the same cycle: the error wins and the flag stays 1.
- btick outside START/DATA/STOP is ignored.
- A line held low (break) produces frame_err. The FSM then waits in IDLE for a new falling edge, so it does not re-trigger while rx stays low.

Optional Feature:
LB_UART_RX_PARITY_EN
- Defined:
  - Adds a PARITY state between DATA and STOP that samples one bit on btick.
  - Adds output parity_err (sticky, cleared by err_clr, reset 0). It is set when the XOR of the data bits and the parity bit is 1 (even parity).
  - On a parity error the byte is still delivered.
- Undefined: no PARITY state and no parity_err port. Frames are DATA_BITS + 1 stop bit.

Decomposition:
- Shared package lb_uart_pkg:
  - state encoding constants (ST_IDLE=2'd0, ST_START=2'd1, ST_DATA=2'd2, ST_STOP=2'd3; ST_PARITY=3'd4 under the macro);
  - TICK_HALF=1'b0 and TICK_FULL=1'b1;
  - DATA_BITS default.
- One sub-module is natural: lb_sync_edge (rx synchroniser plus falling-edge detect).
- The tick counter stays external and is wired at the UART top.

Test Plan:
- Each btick is one bench pulse; one bit = one full-bit period.
- rx sends 0xA5 LSB first, stop=1 -> data=0xA5, data_valid=1 one cycle after the stop btick, frame_err=0; rd_ack -> data_valid=0.
- rx low for only 3 of the 8 half-bit ticks, then high -> START returns to IDLE; data_valid=0; no flags; tick_cs drops.
- Send 0x3C with stop bit=0 -> frame_err=1, data_valid=0; err_clr -> frame_err=0.
- Send 0x11 then 0x22 without rd_ack -> data=0x22, overrun=1. Repeat with rd_ack coincident with the 0x22 completion -> overrun=0, data_valid=1.
- Assert reset during DATA bit 4 of 0xFF -> the next cycle shows state IDLE, all outputs 0. A subsequent 0x5A is received correctly.
- With LB_UART_RX_PARITY_EN: 0x07 with parity bit 0 -> parity_err=1 and data=0x07; with parity bit 1 -> parity_err=0.

Source files
------------

// File: rtl/lb_uart_pkg.sv
// Shared constants for the lb_uart receive path: FSM state encoding and tick-counter mode values.
// The PARITY state exists only when LB_UART_RX_PARITY_EN is defined.
package lb_uart_pkg;

  localparam int DATA_BITS_DEFAULT = 8;

  localparam logic TICK_HALF = 1'b0;
  localparam logic TICK_FULL = 1'b1;

`ifdef LB_UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } rx_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;
`endif

endpackage

// File: rtl/lb_sync_edge.sv
// Multi-flop synchroniser for the asynchronous rx line plus falling-edge detect on the synchronised value.
module lb_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_d;

  // Flops preset to 1 so an idle-high line shows no spurious edge leaving reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
      rx_d   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_d   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = rx_d & ~rx_s;

endmodule

// File: rtl/lb_uart_rx_fsm.sv
// UART receive sequencer driving an external 16/8 baud tick counter; LSB-first deserialiser with
// valid/ack read handshake and sticky error flags. Optional parity via LB_UART_RX_PARITY_EN.
module lb_uart_rx_fsm
  import lb_uart_pkg::*;
#(
  parameter int DATA_BITS   = DATA_BITS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 btick,
  output logic                 tick_cs,
  output logic                 tick_load,
  output logic                 tick_16_or_8,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef LB_UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  input  logic                 err_clr
);

  localparam int             CNT_W    = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  rx_state_t            state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 rx_s;
  logic                 fall;

  lb_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk  (clk),
    .reset(reset),
    .rx   (rx),
    .rx_s (rx_s),
    .fall (fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      shift        <= '0;
      data         <= '0;
      data_valid   <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
`ifdef LB_UART_RX_PARITY_EN
      parity_err   <= 1'b0;
`endif
      tick_cs      <= 1'b0;
      tick_load    <= 1'b0;
      tick_16_or_8 <= TICK_HALF;
    end else begin
      // NOTE: clears are written first so that a later non-blocking assignment in the
      // same cycle (new byte, new error) overrides them -- the last NBA to a signal wins.
      tick_load <= 1'b0;
      if (rd_ack) data_valid <= 1'b0;
      if (err_clr) begin
        frame_err  <= 1'b0;
        overrun    <= 1'b0;
`ifdef LB_UART_RX_PARITY_EN
        parity_err <= 1'b0;
`endif
      end

      unique case (state)
        ST_IDLE: begin
          if (fall) begin
            state        <= ST_START;
            tick_cs      <= 1'b1;
            tick_load    <= 1'b1;
            tick_16_or_8 <= TICK_HALF;
          end
        end

        ST_START: begin
          if (btick) begin
            if (!rx_s) begin
              state        <= ST_DATA;
              tick_load    <= 1'b1;
              tick_16_or_8 <= TICK_FULL;
              bit_cnt      <= '0;
            end else begin
              state   <= ST_IDLE;
              tick_cs <= 1'b0;
            end
          end
        end

        ST_DATA: begin
          if (btick) begin
            shift <= {rx_s, shift[DATA_BITS-1:1]};
            if (bit_cnt == LAST_BIT) begin
`ifdef LB_UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

`ifdef LB_UART_RX_PARITY_EN
        ST_PARITY: begin
          if (btick) begin
            if (^{shift, rx_s}) parity_err <= 1'b1;
            state <= ST_STOP;
          end
        end
`endif

        ST_STOP: begin
          if (btick) begin
            if (rx_s) begin
              data       <= shift;
              data_valid <= 1'b1;
              if (data_valid && !rd_ack) overrun <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state   <= ST_IDLE;
            tick_cs <= 1'b0;
          end
        end

        default: begin
          state   <= ST_IDLE;
          tick_cs <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lb_uart_rx_fsm.sv
// Directed self-checking bench for lb_uart_rx_fsm; btick is driven by the bench, one pulse per bit.
// Parity cases are compiled in when LB_UART_RX_PARITY_EN is defined.
module tb_lb_uart_rx_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       btick;
  logic       tick_cs;
  logic       tick_load;
  logic       tick_16_or_8;
  logic       rd_ack;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
`ifdef LB_UART_RX_PARITY_EN
  logic       parity_err;
`endif
  logic       err_clr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lb_uart_rx_fsm #(
    .DATA_BITS  (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .btick       (btick),
    .tick_cs     (tick_cs),
    .tick_load   (tick_load),
    .tick_16_or_8(tick_16_or_8),
    .rd_ack      (rd_ack),
    .data        (data),
    .data_valid  (data_valid),
    .frame_err   (frame_err),
    .overrun     (overrun),
`ifdef LB_UART_RX_PARITY_EN
    .parity_err  (parity_err),
`endif
    .err_clr     (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_btick();
    btick = 1'b1;
    cyc(1);
    btick = 1'b0;
  endtask

  // Drives one full frame. ack/clr are asserted in the cycle of the stop-bit btick.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input logic ack, input logic clr);
    rx = 1'b0;
    cyc(3);
    check("start_load", {31'd0, tick_load}, 32'd1);
    check("start_cs", {31'd0, tick_cs}, 32'd1);
    check("start_half", {31'd0, tick_16_or_8}, 32'd0);
    cyc(2);
    pulse_btick();
    check("data_load", {31'd0, tick_load}, 32'd1);
    check("data_full", {31'd0, tick_16_or_8}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(4);
      pulse_btick();
    end
`ifdef LB_UART_RX_PARITY_EN
    rx = par;
    cyc(4);
    pulse_btick();
`else
    if (par === 1'bx) rx = 1'bx;
`endif
    rx = stop;
    cyc(4);
    rd_ack  = ack;
    err_clr = clr;
    pulse_btick();
    rd_ack  = 1'b0;
    err_clr = 1'b0;
    check("stop_cs_drop", {31'd0, tick_cs}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; rx = 1'b1; btick = 1'b0; rd_ack = 1'b0; err_clr = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    check("rst_data", {24'd0, data}, 32'h0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    check("rst_cs", {31'd0, tick_cs}, 32'd0);
    check("rst_load", {31'd0, tick_load}, 32'd0);
    check("rst_mode", {31'd0, tick_16_or_8}, 32'd0);

    // Clean 0xA5 frame, then host read.
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    check("a5_data", {24'd0, data}, 32'hA5);
    check("a5_valid", {31'd0, data_valid}, 32'd1);
    check("a5_ferr", {31'd0, frame_err}, 32'd0);
    rx = 1'b1;
    cyc(4);
    rd_ack = 1'b1;
    cyc(1);
    rd_ack = 1'b0;
    check("a5_ack_valid", {31'd0, data_valid}, 32'd0);
    check("a5_ack_data", {24'd0, data}, 32'hA5);
    rd_ack = 1'b1;
    cyc(1);
    rd_ack = 1'b0;
    check("idle_ack_ignored", {31'd0, data_valid}, 32'd0);

    // False start: glitch low then back high before the half-bit tick.
    rx = 1'b0;
    cyc(5);
    check("fs_cs_up", {31'd0, tick_cs}, 32'd1);
    rx = 1'b1;
    cyc(4);
    pulse_btick();
    check("fs_cs_drop", {31'd0, tick_cs}, 32'd0);
    check("fs_valid", {31'd0, data_valid}, 32'd0);
    check("fs_ferr", {31'd0, frame_err}, 32'd0);
    check("fs_ovr", {31'd0, overrun}, 32'd0);
    pulse_btick();
    check("idle_btick_ignored", {31'd0, tick_cs}, 32'd0);

    // Bad stop bit.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    check("3c_ferr", {31'd0, frame_err}, 32'd1);
    check("3c_valid", {31'd0, data_valid}, 32'd0);
    check("3c_data_kept", {24'd0, data}, 32'hA5);
    rx = 1'b1;
    cyc(4);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    check("3c_clr", {31'd0, frame_err}, 32'd0);

    // Overrun: two bytes without a read.
    send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    rx = 1'b1;
    cyc(4);
    check("11_data", {24'd0, data}, 32'h11);
    check("11_ovr", {31'd0, overrun}, 32'd0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    rx = 1'b1;
    cyc(4);
    check("22_data", {24'd0, data}, 32'h22);
    check("22_ovr", {31'd0, overrun}, 32'd1);
    check("22_valid", {31'd0, data_valid}, 32'd1);
    rd_ack = 1'b1; err_clr = 1'b1;
    cyc(1);
    rd_ack = 1'b0; err_clr = 1'b0;
    check("ovr_clr", {31'd0, overrun}, 32'd0);
    check("ovr_ack", {31'd0, data_valid}, 32'd0);

    // Same pair, read coincides with the second completion.
    send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    rx = 1'b1;
    cyc(4);
    send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b0);
    rx = 1'b1;
    cyc(4);
    check("ack_race_ovr", {31'd0, overrun}, 32'd0);
    check("ack_race_valid", {31'd0, data_valid}, 32'd1);
    check("ack_race_data", {24'd0, data}, 32'h22);

    // Error and err_clr in the same cycle: error wins.
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_race_ferr", {31'd0, frame_err}, 32'd1);
    rx = 1'b1;
    cyc(4);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;

    // Reset while receiving bit 4 of 0xFF.
    rx = 1'b0;
    cyc(5);
    pulse_btick();
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      cyc(4);
      pulse_btick();
    end
    cyc(2);
    check("midrst_cs_before", {31'd0, tick_cs}, 32'd1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("midrst_cs", {31'd0, tick_cs}, 32'd0);
    check("midrst_load", {31'd0, tick_load}, 32'd0);
    check("midrst_mode", {31'd0, tick_16_or_8}, 32'd0);
    check("midrst_data", {24'd0, data}, 32'h0);
    check("midrst_valid", {31'd0, data_valid}, 32'd0);
    check("midrst_flags", {30'd0, frame_err, overrun}, 32'd0);
    pulse_btick();
    cyc(3);
    check("midrst_stay_idle", {31'd0, tick_cs}, 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
    check("5a_data", {24'd0, data}, 32'h5A);
    check("5a_valid", {31'd0, data_valid}, 32'd1);
    check("5a_flags", {30'd0, frame_err, overrun}, 32'd0);
    rx = 1'b1;
    cyc(4);
    rd_ack = 1'b1;
    cyc(1);
    rd_ack = 1'b0;

    // Break: line held low through and after the frame.
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("brk_ferr", {31'd0, frame_err}, 32'd1);
    check("brk_valid", {31'd0, data_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(4);
      pulse_btick();
    end
    check("brk_no_retrigger", {31'd0, tick_cs}, 32'd0);
    rx = 1'b1;
    cyc(4);
    check("brk_idle_after_high", {31'd0, tick_cs}, 32'd0);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;

`ifdef LB_UART_RX_PARITY_EN
    check("par_rst", {31'd0, parity_err}, 32'd0);
    send_frame(8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
    check("par_bad_flag", {31'd0, parity_err}, 32'd1);
    check("par_bad_data", {24'd0, data}, 32'h07);
    check("par_bad_valid", {31'd0, data_valid}, 32'd1);
    rx = 1'b1;
    cyc(4);
    rd_ack = 1'b1; err_clr = 1'b1;
    cyc(1);
    rd_ack = 1'b0; err_clr = 1'b0;
    check("par_clr", {31'd0, parity_err}, 32'd0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    check("par_good_flag", {31'd0, parity_err}, 32'd0);
    check("par_good_data", {24'd0, data}, 32'h07);
    rx = 1'b1;
    cyc(4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
